// File: rtl/bus_pkg.sv
// Shared types and constants for the two-requester bus arbiter.
package bus_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int          CNT_W        = 16;
    localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;

    typedef struct packed {
        logic        valid;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } bus_req_t;

endpackage

// File: rtl/bus_arbiter.sv
// Two-requester round-robin arbiter onto a single downstream port, with a
// per-access wait timeout that completes the access with ERR_DATA.
module bus_arbiter
    import bus_pkg::*;
#(
    parameter int          TIMEOUT_CYCLES = 255,
    parameter logic [31:0] ERR_DATA       = ERR_DATA_DEF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic        m0_valid,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,

    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,

    output logic        s_valid,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,

    output logic        timeout_err,
    input  logic        err_clr,
    output logic        grant,
    output logic        busy
);

    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT_CYCLES);

    arb_state_t       state;
    logic             grant_q;
    logic             last_q;
    logic [CNT_W-1:0] wait_cnt;
    logic             err_q;

    bus_req_t r0, r1, rg;
    logic     in_busy, done, tmo, cpl, pick;
    logic [31:0] cpl_data;

    assign r0 = '{valid: m0_valid, addr: m0_addr, wdata: m0_wdata, wstrb: m0_wstrb};
    assign r1 = '{valid: m1_valid, addr: m1_addr, wdata: m1_wdata, wstrb: m1_wstrb};
    assign rg = grant_q ? r1 : r0;

    assign in_busy = (state == BUSY);

    // s_ready beats the timeout when both land in the same cycle; reset
    // suppresses any completion so an interrupted access never sees ready.
    assign done = in_busy && rg.valid && s_ready && !reset;
    assign tmo  = in_busy && rg.valid && !s_ready && (wait_cnt == TO_VAL) && !reset;
    assign cpl  = done || tmo;
    assign cpl_data = done ? s_rdata : ERR_DATA;

    // On a tie the requester not granted last wins; a lone requester wins outright.
    assign pick = (m0_valid && m1_valid) ? ~last_q : m1_valid;

    always_comb begin
        s_valid = in_busy && rg.valid && !tmo && !reset;
        s_addr  = in_busy ? rg.addr  : '0;
        s_wdata = in_busy ? rg.wdata : '0;
        s_wstrb = in_busy ? rg.wstrb : '0;
    end

    always_comb begin
        m0_ready = cpl && !grant_q;
        m1_ready = cpl &&  grant_q;
        m0_rdata = m0_ready ? cpl_data : '0;
        m1_rdata = m1_ready ? cpl_data : '0;
    end

    assign grant       = grant_q;
    assign busy        = in_busy;
    assign timeout_err = err_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= 1'b0;
            last_q   <= 1'b1;
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else begin
            if (tmo)
                err_q <= 1'b1;
            else if (err_clr)
                err_q <= 1'b0;

            case (state)
                IDLE: begin
                    if (m0_valid || m1_valid) begin
                        state    <= BUSY;
                        grant_q  <= pick;
                        wait_cnt <= '0;
                    end
                end
                BUSY: begin
                    if (!rg.valid) begin
                        state <= IDLE;
                    end else if (cpl) begin
                        state  <= IDLE;
                        last_q <= grant_q;
                    end else begin
                        wait_cnt <= wait_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
